button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Front-end stage feeding the clock top level.
- Takes raw active-low push-buttons (mode, field-select, increment, decrement) and conditions them: 2-FF synchronise, debounce, press-edge detect, auto-repeat.
- Produces the set_mode level, set_select[1:0] field index and single-cycle inc_btn/dec_btn pulses consumed by the time counter and display.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synced samples required to accept a new button level (10 ms at 50 MHz).
- REPEAT_DELAY_CYCLES, 25000000: hold time after the first pulse before auto-repeat starts (0.5 s).
- REPEAT_PERIOD_CYCLES, 5000000: interval between auto-repeat pulses (0.1 s).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- key_mode_n, input, 1: raw mode button, 0 = pressed.
- key_sel_n, input, 1: raw field-select button, 0 = pressed.
- key_inc_n, input, 1: raw increment button, 0 = pressed.
- key_dec_n, input, 1: raw decrement button, 0 = pressed.
- set_mode, output, 1: 1 = setting mode active.
- set_select, output, 2: field being edited, 0..3.
- inc_btn, output, 1: one-cycle increment pulse.
- dec_btn, output, 1: one-cycle decrement pulse.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Sync flops and stable levels = 1 (released).
  - Debounce counters = 0; repeat FSMs = IDLE.
  - set_mode=0, set_select=0, inc_btn=0, dec_btn=0.
- Synchroniser: 2-FF per key.
- Debounce, per key:
  - If synced == stable, counter clears.
  - Otherwise counter increments; on reaching DEBOUNCE_CYCLES-1 with synced still different, stable <= synced and counter clears.
  - Any mismatch-free cycle restarts the count (glitch rejection).
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- Press event: stable 1->0, one cycle wide. Release (0->1) generates nothing.
- Latency: a clean raw press yields a press event DEBOUNCE_CYCLES+2 cycles after the raw edge (±1); pulse outputs are registered, +1 cycle.
- Mode key:
  - Each press event toggles set_mode.
  - The 0->1 transition of set_mode also forces set_select=0.
  - Exiting (1->0) holds set_select unchanged.
- Sel key:
  - Press event with set_mode=1: set_select increments, 3 wraps to 0.
  - Ignored when set_mode=0.
- Inc/dec repeat FSM, per key, states IDLE, DELAY, REPEAT:
  - IDLE: on press event emit a pulse, load timer = REPEAT_DELAY_CYCLES-1, go to DELAY.
  - DELAY: timer decrements; at 0 emit a pulse, load REPEAT_PERIOD_CYCLES-1, go to REPEAT.
  - REPEAT: at 0 emit a pulse and reload.
  - Stable release in any state returns to IDLE immediately; no pulse that cycle.
  - Timer width is $clog2 of the larger of the two cycle parameters.
- Gating and simultaneity:
  - inc_btn/dec_btn are gated by set_mode; when set_mode=0 the FSMs still run but outputs stay 0.
  - While both inc and dec are stable-pressed, both outputs are forced 0 and both FSMs hold in IDLE.
  - inc_btn and dec_btn are never 1 in the same cycle.
- Mode toggle in the same cycle as an inc/dec pulse: the pulse uses the pre-toggle set_mode.
- Reset mid-hold: all state clears. A button still held after reset release must first be seen released before it can produce a press.

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined: DELAY/REPEAT states and timer are present, behaviour as above.
- Undefined: FSM and timer are omitted; inc_btn/dec_btn are exactly one pulse per press event; REPEAT_* parameters are accepted but unused.

Decomposition:
- Shared package clock_pkg holds:
  - repeat_state_t enum (IDLE, DELAY, REPEAT);
  - FIELD_MAX = 2'd3;
  - the KEY_PRESSED = 1'b0 constant.
- One sub-module, debounce_cell: 2-FF sync, debounce counter, stable level and press-pulse outputs; parameter DEBOUNCE_CYCLES. Instantiated 4 times.
- Repeat FSMs, mode/select registers and gating stay in button_conditioner.

Test Plan (DEBOUNCE=4, DELAY=20, PERIOD=8):
- Reset, then hold key_mode_n=0 for 10 cycles -> set_mode 0->1 about 7 cycles after the edge, set_select=0; a second press -> set_mode=0.
- Raw key_inc_n bouncing 0/1 every 2 cycles for 12 cycles, then steady 0 with set_mode=1 -> no pulse during bounce, exactly one inc_btn after steady.
- Hold key_inc_n=0 for 60 cycles with set_mode=1 -> pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52; none after release. Without BTN_AUTOREPEAT_EN -> single pulse at t0.
- set_mode=1, press key_sel_n 5 times -> set_select 1,2,3,0,1. With set_mode=0 -> set_select unchanged.
- Press inc and dec within the same cycle and hold -> inc_btn=dec_btn=0 throughout; release dec -> next inc press pulses normally.
- Assert rst_n=0 mid-repeat while key held -> all outputs 0 immediately; after rst_n=1 with key still held -> no pulse until release and re-press.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock front end.
//   repeat_state_t : states of the inc/dec auto-repeat FSM
//   FIELD_MAX      : highest set_select field index (wraps to 0 after it)
//   KEY_PRESSED    : level of a raw/stable key when it is held down
//   KEY_*          : bit positions of each key in the conditioner's key vectors
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

  localparam logic [1:0] FIELD_MAX   = 2'd3;
  localparam logic       KEY_PRESSED = 1'b0;

  localparam int KEY_MODE = 0;
  localparam int KEY_SEL  = 1;
  localparam int KEY_INC  = 2;
  localparam int KEY_DEC  = 3;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw key pins and the time counter / display.
//   key_mode_n, key_sel_n, key_inc_n, key_dec_n : raw active-low buttons
//   set_mode   : 1 while setting mode is active
//   set_select : field being edited, 0..3
//   inc_btn    : one-cycle increment pulse
//   dec_btn    : one-cycle decrement pulse
// master drives the keys and consumes the conditioned outputs;
// slave is the conditioner itself.
interface button_conditioner_if;

  logic       key_mode_n;
  logic       key_sel_n;
  logic       key_inc_n;
  logic       key_dec_n;
  logic       set_mode;
  logic [1:0] set_select;
  logic       inc_btn;
  logic       dec_btn;

  modport master (
    output key_mode_n, key_sel_n, key_inc_n, key_dec_n,
    input  set_mode, set_select, inc_btn, dec_btn
  );

  modport slave (
    input  key_mode_n, key_sel_n, key_inc_n, key_dec_n,
    output set_mode, set_select, inc_btn, dec_btn
  );

endinterface

// File: rtl/button_conditioner_debounce_cell.sv
// debounce_cell: conditions one raw active-low key.
//   clk, rst_n  : clock, asynchronous active-low reset
//   key_n_i     : raw key, 0 = pressed
//   stable_n_o  : debounced key level, 0 = pressed
//   press_o     : one-cycle pulse when the stable level goes 1 -> 0
// Parameter DEBOUNCE_CYCLES: consecutive differing synced samples needed to
// accept a new level.
module debounce_cell
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic stable_n_o,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [1:0]       vld_q;
  logic             armed_q, armed_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A key held across reset would otherwise debounce to "pressed" and look
  // like a fresh press. armed_q only rises once a released level has made it
  // through the synchroniser (vld_q marks when sync2_q holds real samples).
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    armed_d  = armed_q | (vld_q[1] & (sync2_q != KEY_PRESSED));
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      press_d  = armed_q & (sync2_q == KEY_PRESSED);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      vld_q    <= 2'b00;
      armed_q  <= 1'b0;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      vld_q    <= {vld_q[0], 1'b1};
      armed_q  <= armed_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_n_o = stable_q;
  assign press_o    = press_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: turns four raw active-low buttons into the setting
// controls for the clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : button_conditioner_if.slave (raw keys in; set_mode,
//                set_select, inc_btn, dec_btn out)
// Optional build macro BTN_AUTOREPEAT_EN: when defined, holding inc/dec
// auto-repeats after REPEAT_DELAY_CYCLES, then every REPEAT_PERIOD_CYCLES;
// when undefined each press gives exactly one pulse.
module button_conditioner
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 500000,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.slave  bus
);

  logic [3:0] raw_n, stable_n, press;
  logic       inc_held, dec_held, both_held;
  logic [1:0] fire;              // [0] = inc, [1] = dec, before gating
  logic       set_mode_q, set_mode_d;
  logic [1:0] sel_q, sel_d;
  logic       inc_q, inc_d, dec_q, dec_d;

  assign raw_n = {bus.key_dec_n, bus.key_inc_n, bus.key_sel_n, bus.key_mode_n};

  for (genvar i = 0; i < 4; i++) begin : g_key
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_n_i   (raw_n[i]),
      .stable_n_o(stable_n[i]),
      .press_o   (press[i])
    );
  end

  // Mode and select react only to press events, never to the held level.
  logic unused_stable;
  assign unused_stable = ^stable_n[KEY_SEL:KEY_MODE];

  assign inc_held  = (stable_n[KEY_INC] == KEY_PRESSED);
  assign dec_held  = (stable_n[KEY_DEC] == KEY_PRESSED);
  assign both_held = inc_held & dec_held;

`ifdef BTN_AUTOREPEAT_EN
  localparam int TMR_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] DLY_LOAD = TMR_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TMR_W-1:0] PER_LOAD = TMR_W'(REPEAT_PERIOD_CYCLES - 1);

  repeat_state_t    state_q [2];
  repeat_state_t    state_d [2];
  logic [TMR_W-1:0] tmr_q   [2];
  logic [TMR_W-1:0] tmr_d   [2];
  logic [1:0]       held, pev;

  assign held = {dec_held, inc_held};
  assign pev  = {press[KEY_DEC], press[KEY_INC]};

  // Release (or the inc+dec chord) wins over any timer expiry that cycle.
  always_comb begin
    fire = 2'b00;
    for (int k = 0; k < 2; k++) begin
      state_d[k] = state_q[k];
      tmr_d[k]   = tmr_q[k];
      if (!held[k] || both_held) begin
        state_d[k] = IDLE;
      end else begin
        case (state_q[k])
          IDLE: if (pev[k]) begin
            fire[k]    = 1'b1;
            tmr_d[k]   = DLY_LOAD;
            state_d[k] = DELAY;
          end
          DELAY, REPEAT: if (tmr_q[k] == '0) begin
            fire[k]    = 1'b1;
            tmr_d[k]   = PER_LOAD;
            state_d[k] = REPEAT;
          end else begin
            tmr_d[k] = tmr_q[k] - 1'b1;
          end
          default: state_d[k] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= IDLE;
        tmr_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= state_d[k];
        tmr_q[k]   <= tmr_d[k];
      end
    end
  end
`else
  assign fire = {press[KEY_DEC], press[KEY_INC]};

  // The REPEAT_* parameters are accepted but have no effect in this build.
  logic [31:0] unused_repeat_cfg;
  assign unused_repeat_cfg = 32'(REPEAT_DELAY_CYCLES) ^ 32'(REPEAT_PERIOD_CYCLES);
`endif

  // All decisions below use the pre-toggle set_mode_q, so an inc/dec pulse
  // coinciding with a mode press is gated by the old mode.
  always_comb begin
    set_mode_d = set_mode_q ^ press[KEY_MODE];
    sel_d      = sel_q;
    if (press[KEY_MODE] && !set_mode_q) begin
      sel_d = '0;
    end else if (press[KEY_SEL] && set_mode_q) begin
      sel_d = (sel_q == FIELD_MAX) ? 2'd0 : sel_q + 2'd1;
    end
    inc_d = fire[0] & set_mode_q & ~both_held;
    dec_d = fire[1] & set_mode_q & ~both_held & ~inc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_mode_q <= 1'b0;
      sel_q      <= 2'd0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
    end else begin
      set_mode_q <= set_mode_d;
      sel_q      <= sel_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
    end
  end

  assign bus.set_mode   = set_mode_q;
  assign bus.set_select = sel_q;
  assign bus.inc_btn    = inc_q;
  assign bus.dec_btn    = dec_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with DEBOUNCE=4, DELAY=20, PERIOD=8.
// A clean raw press driven at a falling edge when cyc == c0 is expected to
// produce its first inc/dec pulse visible at the falling edge with cyc == c0+7.
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int DLY = 20;
  localparam int PER = 8;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int KMODE = 0;
  localparam int KSEL  = 1;
  localparam int KINC  = 2;
  localparam int KDEC  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  button_conditioner_if bus();

  button_conditioner #(
    .DEBOUNCE_CYCLES     (DEB),
    .REPEAT_DELAY_CYCLES (DLY),
    .REPEAT_PERIOD_CYCLES(PER)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit is_dec;
    int at;
  } pulse_t;
  pulse_t exp_q[$];
  pulse_t e;

  // Scoreboard: every observed pulse must match the oldest expected one.
  always @(negedge clk) begin
    if (bus.inc_btn && bus.dec_btn) begin
      n_checks++;
      n_fail++;
      $display("FAIL both_pulses: inc_btn and dec_btn both 1 at cycle %0d, required at most one", cyc);
    end else if (bus.inc_btn || bus.dec_btn) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: %s at cycle %0d, no pulse required",
                 bus.dec_btn ? "dec_btn" : "inc_btn", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.is_dec != bus.dec_btn || e.at != cyc) begin
          n_fail++;
          $display("FAIL pulse_match: got %s at cycle %0d, required %s at cycle %0d",
                   bus.dec_btn ? "dec" : "inc", cyc, e.is_dec ? "dec" : "inc", e.at);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic push(input bit is_dec, input int at);
    pulse_t p;
    p.is_dec = is_dec;
    p.at     = at;
    exp_q.push_back(p);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      KMODE:   bus.key_mode_n = v;
      KSEL:    bus.key_sel_n  = v;
      KINC:    bus.key_inc_n  = v;
      default: bus.key_dec_n  = v;
    endcase
  endtask

  // Clean press: expected first pulse at c0+7, repeats at +DLY then +PER.
  task automatic press_key(input int k, input int hold, input int rel,
                           input bit pulse, input int n_rep);
    int c0;
    @(negedge clk);
    set_key(k, 1'b0);
    c0 = cyc;
    if (pulse) begin
      push(k == KDEC, c0 + 7);
      for (int r = 0; r < n_rep; r++) push(k == KDEC, c0 + 7 + DLY + r * PER);
    end
    repeat (hold) @(negedge clk);
    set_key(k, 1'b1);
    repeat (rel) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input int m, input int s);
    check({tag, "_set_mode"},   bus.set_mode,   m);
    check({tag, "_set_select"}, bus.set_select, s);
    check({tag, "_inc_btn"},    bus.inc_btn,    0);
    check({tag, "_dec_btn"},    bus.dec_btn,    0);
  endtask

  typedef struct {
    int    key;
    bit    mode;
    int    sel;
    bit    pulse;
    string name;
  } vec_t;
  vec_t tbl[13];

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation did not finish within 100000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{KMODE, 1'b1, 0, 1'b0, "enter_mode"};
    tbl[1]  = '{KSEL,  1'b1, 1, 1'b0, "sel_1"};
    tbl[2]  = '{KSEL,  1'b1, 2, 1'b0, "sel_2"};
    tbl[3]  = '{KINC,  1'b1, 2, 1'b1, "inc_in_mode"};
    tbl[4]  = '{KSEL,  1'b1, 3, 1'b0, "sel_3"};
    tbl[5]  = '{KSEL,  1'b1, 0, 1'b0, "sel_wrap_0"};
    tbl[6]  = '{KSEL,  1'b1, 1, 1'b0, "sel_1_again"};
    tbl[7]  = '{KDEC,  1'b1, 1, 1'b1, "dec_in_mode"};
    tbl[8]  = '{KMODE, 1'b0, 1, 1'b0, "exit_keeps_sel"};
    tbl[9]  = '{KSEL,  1'b0, 1, 1'b0, "sel_ignored"};
    tbl[10] = '{KINC,  1'b0, 1, 1'b0, "inc_gated"};
    tbl[11] = '{KDEC,  1'b0, 1, 1'b0, "dec_gated"};
    tbl[12] = '{KMODE, 1'b1, 0, 1'b0, "reenter_clears_sel"};

    bus.key_mode_n = 1'b1;
    bus.key_sel_n  = 1'b1;
    bus.key_inc_n  = 1'b1;
    bus.key_dec_n  = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset", 0, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      press_key(tbl[i].key, 8, 10, tbl[i].pulse, 0);
      check({tbl[i].name, "_set_mode"},   bus.set_mode,   tbl[i].mode);
      check({tbl[i].name, "_set_select"}, bus.set_select, tbl[i].sel);
      check_drained({tbl[i].name, "_pending"});
    end

    // Bouncing inc (0/1 every 2 cycles) then steady press: one pulse only.
    for (int i = 0; i < 12; i++) begin
      set_key(KINC, ((i / 2) % 2) != 0);
      @(negedge clk);
    end
    press_key(KINC, 12, 10, 1'b1, 0);
    check_drained("bounce_then_steady");

    // Long hold: auto-repeat at t0, +20, +28, +36, +44, +52 when enabled.
    press_key(KINC, 60, 12, 1'b1, AUTO ? 5 : 0);
    check_drained("hold_repeat");

    // inc and dec pressed together: nothing, then a fresh inc works.
    @(negedge clk);
    set_key(KINC, 1'b0);
    set_key(KDEC, 1'b0);
    repeat (30) @(negedge clk);
    set_key(KDEC, 1'b1);
    repeat (10) @(negedge clk);
    set_key(KINC, 1'b1);
    repeat (10) @(negedge clk);
    check_drained("both_held_silent");
    press_key(KINC, 8, 10, 1'b1, 0);
    check_drained("inc_after_both");

    // Move select off 0 so the reset clear is visible.
    press_key(KSEL, 8, 10, 1'b0, 0);
    check("pre_reset_set_select", bus.set_select, 1);

    // Reset while inc is held and repeating.
    begin
      int c0;
      @(negedge clk);
      set_key(KINC, 1'b0);
      c0 = cyc;
      push(1'b0, c0 + 7);
      if (AUTO) push(1'b0, c0 + 7 + DLY);
      repeat (27) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_outputs("mid_hold_reset", 0, 0);
      check_drained("pre_reset_pulses");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      press_key(KMODE, 8, 10, 1'b0, 0);
      check("post_reset_set_mode", bus.set_mode, 1);
      repeat (30) @(negedge clk);
      check_drained("held_through_reset");
      set_key(KINC, 1'b1);
      repeat (10) @(negedge clk);
      check_drained("release_after_reset");
      press_key(KINC, 8, 10, 1'b1, 0);
      check_drained("repress_after_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
